// File: rtl/fb_swap_scheduler_pkg.sv
// Shared types and default sizing for the framebuffer swap scheduler.
package fb_swap_scheduler_pkg;

    localparam int unsigned MAX_OUTSTANDING_DEF = 15;
    localparam int unsigned SKIP_CNT_BITS_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_SWAP0     = 3'd2,
        ST_RUN_DRAW  = 3'd3,
        ST_RUN_READY = 3'd4
    } sched_state_e;

    // One-cycle control pulses issued by the scheduler.
    typedef struct packed {
        logic mem_switch;
        logic gfx_start;
        logic frame_skipped;
    } sched_pulse_t;

endpackage

// File: rtl/fb_swap_scheduler_if.sv
// Producer/display-side signal bundle of the framebuffer swap scheduler.
interface fb_swap_scheduler_if
    import fb_swap_scheduler_pkg::*;
#(
    parameter int unsigned SKIP_CNT_BITS = SKIP_CNT_BITS_DEF
);
    logic                     gfx_last;
    logic                     aw_hs;
    logic                     b_hs;
    logic                     vsync;
    logic                     fifo_almost_full;
    logic                     mem_switch;
    logic                     gfx_start;
    logic                     disp_enable;
    logic                     frame_skipped;
    logic [SKIP_CNT_BITS-1:0] skip_count;
    logic                     wr_error;

    modport slave (
        input  gfx_last, aw_hs, b_hs, vsync, fifo_almost_full,
        output mem_switch, gfx_start, disp_enable, frame_skipped, skip_count, wr_error
    );

    modport master (
        output gfx_last, aw_hs, b_hs, vsync, fifo_almost_full,
        input  mem_switch, gfx_start, disp_enable, frame_skipped, skip_count, wr_error
    );
endinterface

// File: rtl/fb_swap_scheduler_axi_wr_tracker.sv
// Outstanding AXI write counter (AW accepted, B not yet seen) with sticky
// overflow/underflow error. The counter holds its value on an illegal step.
module axi_wr_tracker #(
    parameter  int unsigned MAX_OUTSTANDING = 15,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             aw_hs,
    input  logic             b_hs,
    output logic [CNT_W-1:0] count,
    output logic             idle,
    output logic             error
);

    // Count, zero flag and sticky error all update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            idle  <= 1'b1;
            error <= 1'b0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10: begin
                    if (count == CNT_W'(MAX_OUTSTANDING)) begin
                        error <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                        idle  <= 1'b0;
                    end
                end
                2'b01: begin
                    if (count == '0) begin
                        error <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                        idle  <= (count == CNT_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_swap_scheduler.sv
// Double-buffered framebuffer swap sequencer: swaps producer/consumer
// buffers on a vsync falling edge once the frame is complete and all writes
// have retired; otherwise counts the frame as skipped.
module fb_swap_scheduler
    import fb_swap_scheduler_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int unsigned SKIP_CNT_BITS   = SKIP_CNT_BITS_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    fb_swap_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]         trk_count;
    logic                     trk_idle;
    logic                     trk_error;
    logic                     vsync_q;
    logic                     vs_fall;
    logic                     drained;
    logic                     done_flag;
    logic                     running;
    logic [SKIP_CNT_BITS-1:0] skip_q;
    sched_pulse_t             pulse_q;
    sched_state_e             state;

    axi_wr_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .aw_hs  (bus.aw_hs),
        .b_hs   (bus.b_hs),
        .count  (trk_count),
        .idle   (trk_idle),
        .error  (trk_error)
    );

    // The raw count is kept on the tracker port for debug visibility only.
    logic unused_trk_count;
    assign unused_trk_count = ^trk_count;

    assign vs_fall = vsync_q & ~bus.vsync;
    assign drained = done_flag & trk_idle & ~bus.aw_hs;

    // Vsync history for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b0;
        else        vsync_q <= bus.vsync;
    end

    // Swap FSM with frame-done tracking, skip counter and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pulse_q   <= '0;
            done_flag <= 1'b0;
            running   <= 1'b0;
            skip_q    <= '0;
        end else begin
            pulse_q <= '0;
            case (state)
                ST_IDLE: begin
                    pulse_q.gfx_start <= 1'b1;
                    state             <= ST_FILL;
                end
                ST_FILL: begin
                    if (bus.gfx_last) done_flag <= 1'b1;
                    // First swap is free-running: the display is not yet consuming.
                    if (drained) begin
                        pulse_q.mem_switch <= 1'b1;
                        pulse_q.gfx_start  <= 1'b1;
                        done_flag          <= 1'b0;
                        running            <= 1'b1;
                        state              <= ST_SWAP0;
                    end
                end
                ST_SWAP0: begin
                    state <= ST_RUN_DRAW;
                end
                ST_RUN_DRAW: begin
                    if (bus.gfx_last) done_flag <= 1'b1;
                    if (vs_fall && drained) begin
                        pulse_q.mem_switch <= 1'b1;
                        pulse_q.gfx_start  <= 1'b1;
                        done_flag          <= 1'b0;
                    end else if (vs_fall) begin
                        pulse_q.frame_skipped <= 1'b1;
                        if (skip_q != '1) skip_q <= skip_q + SKIP_CNT_BITS'(1);
                    end else if (drained) begin
                        state <= ST_RUN_READY;
                    end
                end
                ST_RUN_READY: begin
                    if (vs_fall) begin
                        pulse_q.mem_switch <= 1'b1;
                        pulse_q.gfx_start  <= 1'b1;
                        done_flag          <= 1'b0;
                        state              <= ST_RUN_DRAW;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_switch    = pulse_q.mem_switch;
    assign bus.gfx_start     = pulse_q.gfx_start;
    assign bus.frame_skipped = pulse_q.frame_skipped;
    assign bus.skip_count    = skip_q;
    assign bus.wr_error      = trk_error;
    // Pixel stream backs off immediately when the display fifo fills.
    assign bus.disp_enable   = running & ~bus.fifo_almost_full;

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Directed bench for the framebuffer swap scheduler.
module tb_fb_swap_scheduler;
    import fb_swap_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses;

    always #5 clk = ~clk;

    fb_swap_scheduler_if bus ();

    fb_swap_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_switch"},    32'(bus.mem_switch),    32'd0);
        check({tag, "_gfx_start"},     32'(bus.gfx_start),     32'd0);
        check({tag, "_disp_enable"},   32'(bus.disp_enable),   32'd0);
        check({tag, "_frame_skipped"}, 32'(bus.frame_skipped), 32'd0);
        check({tag, "_skip_count"},    32'(bus.skip_count),    32'd0);
        check({tag, "_wr_error"},      32'(bus.wr_error),      32'd0);
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.gfx_last         = 1'b0;
        bus.aw_hs            = 1'b0;
        bus.b_hs             = 1'b0;
        bus.vsync            = 1'b1;
        bus.fifo_almost_full = 1'b0;
        repeat (2) tick();

        // 1: reset state and first gfx_start
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();
        check("t1_gfx_start", 32'(bus.gfx_start), 32'd1);
        check("t1_mem_switch", 32'(bus.mem_switch), 32'd0);
        check("t1_disp", 32'(bus.disp_enable), 32'd0);
        tick();
        check("t1_gfx_start_off", 32'(bus.gfx_start), 32'd0);

        // 2: fill first frame, swap after writes retire
        bus.aw_hs = 1'b1;
        repeat (3) tick();
        bus.aw_hs = 1'b0;
        check("t2_count3", 32'(dut.u_trk.count), 32'd3);
        bus.gfx_last = 1'b1; tick(); bus.gfx_last = 1'b0;
        bus.b_hs = 1'b1; tick(); bus.b_hs = 1'b0; tick();
        bus.b_hs = 1'b1; tick(); bus.b_hs = 1'b0; tick();
        bus.b_hs = 1'b1; tick(); bus.b_hs = 1'b0;
        check("t2_no_switch_yet", 32'(bus.mem_switch), 32'd0);
        tick();
        check("t2_mem_switch", 32'(bus.mem_switch), 32'd1);
        check("t2_gfx_start", 32'(bus.gfx_start), 32'd1);
        check("t2_disp", 32'(bus.disp_enable), 32'd1);
        tick();
        check("t2_mem_switch_off", 32'(bus.mem_switch), 32'd0);
        check("t2_disp_hold", 32'(bus.disp_enable), 32'd1);

        // 3: vs_fall with writes outstanding skips; later vs_fall swaps
        bus.aw_hs = 1'b1; repeat (2) tick(); bus.aw_hs = 1'b0;
        bus.gfx_last = 1'b1; tick(); bus.gfx_last = 1'b0;
        bus.vsync = 1'b0; tick();
        check("t3_skipped", 32'(bus.frame_skipped), 32'd1);
        check("t3_skip_count", 32'(bus.skip_count), 32'd1);
        check("t3_no_switch", 32'(bus.mem_switch), 32'd0);
        bus.vsync = 1'b1; tick();
        check("t3_skipped_off", 32'(bus.frame_skipped), 32'd0);
        bus.b_hs = 1'b1; repeat (2) tick(); bus.b_hs = 1'b0;
        tick();
        check("t3_ready_no_switch", 32'(bus.mem_switch), 32'd0);
        bus.vsync = 1'b0; tick();
        check("t3_mem_switch", 32'(bus.mem_switch), 32'd1);
        check("t3_gfx_start", 32'(bus.gfx_start), 32'd1);
        check("t3_skip_hold", 32'(bus.skip_count), 32'd1);
        bus.vsync = 1'b1; tick();
        check("t3_mem_switch_off", 32'(bus.mem_switch), 32'd0);

        // 4: long vsync low in RUN_READY yields a single swap
        bus.gfx_last = 1'b1; tick(); bus.gfx_last = 1'b0;
        tick();
        bus.vsync = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) check("t4_first_edge", 32'(bus.mem_switch), 32'd1);
            if (bus.mem_switch) pulses++;
        end
        check("t4_one_pulse", 32'(pulses), 32'd1);
        bus.vsync = 1'b1; tick();

        // vs_fall and drained together in RUN_DRAW swap directly
        bus.gfx_last = 1'b1; tick(); bus.gfx_last = 1'b0;
        bus.vsync = 1'b0; tick();
        check("t4b_mem_switch", 32'(bus.mem_switch), 32'd1);
        check("t4b_no_skip", 32'(bus.frame_skipped), 32'd0);
        bus.vsync = 1'b1; tick();

        // 5: counter corner cases
        bus.aw_hs = 1'b1; tick();
        bus.b_hs = 1'b1; tick();
        bus.aw_hs = 1'b0; bus.b_hs = 1'b0;
        check("t5_both_hold", 32'(dut.u_trk.count), 32'd1);
        bus.b_hs = 1'b1; tick(); bus.b_hs = 1'b0;
        check("t5_count0", 32'(dut.u_trk.count), 32'd0);
        check("t5_no_err", 32'(bus.wr_error), 32'd0);
        bus.aw_hs = 1'b1;
        repeat (15) tick();
        check("t5_count15", 32'(dut.u_trk.count), 32'd15);
        check("t5_no_err15", 32'(bus.wr_error), 32'd0);
        tick();
        bus.aw_hs = 1'b0;
        check("t5_sat15", 32'(dut.u_trk.count), 32'd15);
        check("t5_ovf_err", 32'(bus.wr_error), 32'd1);

        // 6: combinational disp gating, async reset mid-run, underflow
        bus.fifo_almost_full = 1'b1; #1;
        check("t6_disp_off", 32'(bus.disp_enable), 32'd0);
        bus.fifo_almost_full = 1'b0; #1;
        check("t6_disp_on", 32'(bus.disp_enable), 32'd1);
        rst_n = 1'b0; #1;
        check_all_zero("t6_rst");
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_gfx_start", 32'(bus.gfx_start), 32'd1);
        check("t6_disp", 32'(bus.disp_enable), 32'd0);
        tick();
        check("t6_gfx_start_off", 32'(bus.gfx_start), 32'd0);
        bus.b_hs = 1'b1; tick(); bus.b_hs = 1'b0;
        check("t6_udf_err", 32'(bus.wr_error), 32'd1);
        check("t6_udf_count", 32'(dut.u_trk.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
